// File: rtl/hash_vec_pkg.sv
// Shared types and constants for the hash vector sequencer.
package hash_vec_pkg;

  typedef enum logic [2:0] {
    IDLE, CRST, SETTLE, PULSE, WAIT_DONE, CHECK, GAP, FINISH
  } state_e;

  localparam int CRST_CYC   = 2;
  localparam int SETTLE_CYC = 1;
  localparam int GAP_CYC    = 3;

  // Sliced down to DIG_W by users; digests wider than 64 bits are not expected.
  localparam int                MARK_W       = 64;
  localparam logic [MARK_W-1:0] TIMEOUT_MARK = '1;

endpackage

// File: rtl/hash_vec_sequencer_if.sv
// Start/Done handshake between the sequencer (master) and the hash core (slave).
interface hash_vec_sequencer_if #(
  parameter int MSG_W = 32,
  parameter int DIG_W = 32
);
  logic             core_rst;
  logic             core_start;
  logic [MSG_W-1:0] core_msg;
  logic             core_done;
  logic [DIG_W-1:0] core_digest;

  modport master (output core_rst, core_start, core_msg, input  core_done, core_digest);
  modport slave  (input  core_rst, core_start, core_msg, output core_done, core_digest);
endinterface

// File: rtl/hash_vec_ram.sv
// Single-write, single registered-read table; a same-cycle write to the read address is forwarded.
module hash_vec_ram
  import hash_vec_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/hash_vec_sequencer.sv
// Drives the hash core through a table of vectors and scores each digest.
// Optional digest log table and read port: HASH_VEC_DIGEST_LOG_EN.
module hash_vec_sequencer
  import hash_vec_pkg::*;
#(
  parameter int NUM_VEC = 64,
  parameter int ADDR_W  = 6,
  parameter int MSG_W   = 32,
  parameter int DIG_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DIG_W-1:0]  ld_data,
  input  logic              run,
  input  logic [ADDR_W:0]   vec_count,
  hash_vec_sequencer_if.master core,
  output logic              busy,
  output logic              seq_done,
  output logic [ADDR_W:0]   err_count,
  output logic              timeout_flag,
  output logic [ADDR_W-1:0] first_fail
`ifdef HASH_VEC_DIGEST_LOG_EN
  ,
  input  logic [ADDR_W-1:0] log_addr,
  output logic [DIG_W-1:0]  log_data
`endif
);
  localparam int            TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] NV = (ADDR_W+1)'(NUM_VEC);

  state_e            state;
  logic [TW-1:0]     cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n_lat;
  logic [DIG_W-1:0]  dig_q;
  logic              rst_q, start_q;

  logic [MSG_W-1:0]  msg_rd;
  logic [DIG_W-1:0]  exp_rd;
  logic              wr_ok, gap_end, last_vec, rd_en, to_hit;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   err_inc;

  assign wr_ok    = ld_we & ~busy;
  assign last_vec = ({1'b0, idx} + (ADDR_W+1)'(1)) == n_lat;
  assign gap_end  = (state == GAP) && (cnt == TW'(GAP_CYC - 1));
  assign to_hit   = (state == WAIT_DONE) && !core.core_done && (cnt == TW'(TIMEOUT - 1));
  assign err_inc  = (err_count == NV) ? err_count : err_count + (ADDR_W+1)'(1);

  // Tables are read one cycle ahead so msg/exp are valid from the first CRST cycle.
  assign rd_en   = ((state == IDLE) && run) || (gap_end && !last_vec);
  assign rd_addr = (state == IDLE) ? '0 : idx + ADDR_W'(1);

  hash_vec_ram #(.DEPTH(NUM_VEC), .AW(ADDR_W), .DW(MSG_W)) u_msg (
    .clk, .rst, .we(wr_ok & ~ld_sel), .waddr(ld_addr), .wdata(ld_data[MSG_W-1:0]),
    .re(rd_en), .raddr(rd_addr), .rdata(msg_rd)
  );

  hash_vec_ram #(.DEPTH(NUM_VEC), .AW(ADDR_W), .DW(DIG_W)) u_exp (
    .clk, .rst, .we(wr_ok & ld_sel), .waddr(ld_addr), .wdata(ld_data),
    .re(rd_en), .raddr(rd_addr), .rdata(exp_rd)
  );

`ifdef HASH_VEC_DIGEST_LOG_EN
  logic             log_we;
  logic [DIG_W-1:0] log_wd;

  assign log_we = (state == CHECK) || to_hit;
  assign log_wd = (state == CHECK) ? dig_q : TIMEOUT_MARK[DIG_W-1:0];

  hash_vec_ram #(.DEPTH(NUM_VEC), .AW(ADDR_W), .DW(DIG_W)) u_log (
    .clk, .rst(1'b0), .we(log_we), .waddr(idx), .wdata(log_wd),
    .re(1'b1), .raddr(log_addr), .rdata(log_data)
  );
`endif

  assign core.core_rst   = rst_q;
  assign core.core_start = start_q;
  assign core.core_msg   = msg_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      n_lat        <= NV;
      dig_q        <= '0;
      rst_q        <= 1'b1;
      start_q      <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      err_count    <= '0;
      timeout_flag <= 1'b0;
      first_fail   <= '0;
    end else begin
      case (state)
        IDLE: if (run) begin
          n_lat        <= (vec_count == '0 || vec_count > NV) ? NV : vec_count;
          err_count    <= '0;
          timeout_flag <= 1'b0;
          first_fail   <= '0;
          seq_done     <= 1'b0;
          busy         <= 1'b1;
          idx          <= '0;
          cnt          <= '0;
          state        <= CRST;
        end
        CRST: if (cnt == TW'(CRST_CYC - 1)) begin
          cnt   <= '0;
          rst_q <= 1'b0;
          state <= SETTLE;
        end else cnt <= cnt + TW'(1);
        SETTLE: if (cnt == TW'(SETTLE_CYC - 1)) begin
          cnt     <= '0;
          start_q <= 1'b1;
          state   <= PULSE;
        end else cnt <= cnt + TW'(1);
        PULSE: begin
          start_q <= 1'b0;
          cnt     <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: if (core.core_done) begin
          dig_q <= core.core_digest;
          state <= CHECK;
        end else if (to_hit) begin
          // A hung vector skips CHECK but still scores as an error.
          timeout_flag <= 1'b1;
          err_count    <= err_inc;
          if (err_count == '0) first_fail <= idx;
          cnt   <= '0;
          state <= GAP;
        end else cnt <= cnt + TW'(1);
        CHECK: begin
          if (dig_q != exp_rd) begin
            err_count <= err_inc;
            if (err_count == '0) first_fail <= idx;
          end
          cnt   <= '0;
          state <= GAP;
        end
        GAP: if (gap_end) begin
          cnt   <= '0;
          rst_q <= 1'b1;
          if (last_vec) begin
            busy     <= 1'b0;
            seq_done <= 1'b1;
            state    <= FINISH;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= CRST;
          end
        end else cnt <= cnt + TW'(1);
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_vec_sequencer.sv
// Randomized bench: behavioural hash core, table model and a per-cycle handshake monitor.
module tb_hash_vec_sequencer;
  localparam int NV = 64;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk, rst, ld_we, ld_sel, run;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [AW:0]   vec_count;
  logic          busy, seq_done, timeout_flag;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_fail;
`ifdef HASH_VEC_DIGEST_LOG_EN
  logic [AW-1:0] log_addr;
  logic [31:0]   log_data;
`endif

  hash_vec_sequencer_if #(.MSG_W(32), .DIG_W(32)) cif ();

  hash_vec_sequencer #(.NUM_VEC(NV), .ADDR_W(AW), .MSG_W(32), .DIG_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .run(run), .vec_count(vec_count), .core(cif.master), .busy(busy), .seq_done(seq_done),
    .err_count(err_count), .timeout_flag(timeout_flag), .first_fail(first_fail)
`ifdef HASH_VEC_DIGEST_LOG_EN
    , .log_addr(log_addr), .log_data(log_data)
`endif
  );

  int          n_chk = 0, n_err = 0, cyc = 0;
  logic [31:0] m_msg [NV];
  logic [31:0] m_exp [NV];
  int          lat_arr [NV];
  int          hang_vec = -1, lat_force = 0;
  int          run_cyc = 0, m_n = 0, n_starts = 0, core_k = 0;
  bit          mon_active = 0;

  function automatic logic [31:0] hf(input logic [31:0] m);
    return (m * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Cycles from one CRST entry to the next: 2+1+1+latency+1+3, or no CHECK on timeout.
  function automatic int vec_dur(input int k);
    if (k == hang_vec) return 7 + TO;
    return 8 + lat_arr[k];
  endfunction

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Behavioural hash core: random latency, optional hang, occasional stray Done afterwards.
  initial begin : core_model
    int cd, spur; bit pend; logic [31:0] ml;
    cd = 0; spur = 0; pend = 0; ml = '0;
    cif.core_done = 1'b0; cif.core_digest = '0;
    forever begin
      @(negedge clk);
      cif.core_done = 1'b0;
      if (cif.core_rst) begin
        pend = 0; spur = 0;
      end else begin
        if (pend) begin
          cd--;
          if (cd == 0) begin
            cif.core_done = 1'b1; cif.core_digest = hf(ml); pend = 0;
            spur = int'($urandom_range(0, 1)) * 2;
          end
        end else if (spur > 0) begin
          spur--;
          if (spur == 0) begin cif.core_done = 1'b1; cif.core_digest = ~hf(ml); end
        end
        if (cif.core_start && core_k < NV) begin
          ml = cif.core_msg;
          lat_arr[core_k] = (lat_force > 0) ? lat_force : int'($urandom_range(1, 6));
          cd   = lat_arr[core_k];
          pend = (core_k != hang_vec);
          core_k++;
        end
      end
    end
  end

  // Per-cycle monitor: start timing, width, message and the reset window before each pulse.
  initial begin : monitor
    bit ps, sdp; logic [3:0] rh; int last_s, k;
    ps = 0; sdp = 0; rh = '1; last_s = 0;
    forever begin
      @(negedge clk);
      if (mon_active) begin
        if (ps) chk("start_width", 64'(cif.core_start), 64'(0));
        if (cif.core_start) begin
          k = n_starts;
          if (k >= NV) chk("start_count_over", 64'(k), 64'(NV - 1));
          else begin
            chk("start_cycle", 64'(cyc), 64'((k == 0) ? run_cyc + 4 : last_s + vec_dur(k - 1)));
            chk("start_msg", 64'(cif.core_msg), 64'(m_msg[k]));
            chk("rst_window", 64'({rh[2:0], cif.core_rst}), 64'(4'b1100));
          end
          last_s = cyc;
          n_starts++;
        end
        if (seq_done && !sdp && m_n > 0)
          chk("done_cycle", 64'(cyc), 64'(last_s + vec_dur(m_n - 1) - 3));
      end
      ps = cif.core_start; sdp = seq_done; rh = {rh[2:0], cif.core_rst};
    end
  end

  task automatic load(input bit sel, input int a, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1; ld_sel = sel; ld_addr = AW'(a); ld_data = d;
    @(negedge clk);
    ld_we = 0;
  endtask

`ifdef HASH_VEC_DIGEST_LOG_EN
  task automatic log_chk(input int a, input logic [31:0] e);
    @(negedge clk); log_addr = AW'(a);
    @(negedge clk); chk("log_read", 64'(log_data), 64'(e));
  endtask
`endif

  task automatic do_run(input int vc, input int hang, input bit sim_wr, input bit poke, input int rst_vec);
    int n, t, seen, m_e, m_ff; bit m_tf, bad, done;
    n = (vc == 0 || vc > NV) ? NV : vc;
    m_n = n; hang_vec = hang; n_starts = 0; core_k = 0;
    @(negedge clk);
    if (sim_wr) begin
      m_msg[0] = $urandom; ld_we = 1; ld_sel = 0; ld_addr = '0; ld_data = m_msg[0];
    end
    run = 1; vec_count = (AW+1)'(vc); run_cyc = cyc; mon_active = 1;
    @(negedge clk);
    run = 0; ld_we = 0;
    t = 0; seen = 0; done = 0;
    while (!done && t < 4000) begin
      if (seq_done) done = 1;
      else begin
        if (poke && t == 10) begin
          ld_we = 1; ld_sel = 0; ld_addr = 6'd1; ld_data = ~m_msg[1]; run = 1; vec_count = 7'd2;
        end else if (poke && t == 11) begin
          ld_sel = 1; ld_addr = 6'd2; ld_data = ~m_exp[2]; run = 0;
        end else begin
          ld_we = 0; run = 0;
        end
        if (rst_vec >= 0 && cif.core_start) begin
          seen++;
          if (seen == rst_vec + 1) begin
            @(negedge clk);
            m_e = 0;
            for (int i = 0; i < rst_vec; i++) if (hf(m_msg[i]) != m_exp[i]) m_e++;
            chk("pre_rst_err", 64'(err_count), 64'(m_e));
            mon_active = 0; rst = 1;
            @(negedge clk);
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_core_rst", 64'(cif.core_rst), 64'(1));
            chk("rst_err", 64'(err_count), 64'(0));
            chk("rst_start", 64'(cif.core_start), 64'(0));
            chk("rst_msg", 64'(cif.core_msg), 64'(0));
            chk("rst_seq_done", 64'(seq_done), 64'(0));
            rst = 0;
            return;
          end
        end
        @(negedge clk);
        t++;
      end
    end
    ld_we = 0; run = 0;
    chk("run_completes", 64'(done), 64'(1));
    m_e = 0; m_ff = 0; m_tf = 0;
    for (int i = 0; i < n; i++) begin
      bad = (i == hang) || (hf(m_msg[i]) != m_exp[i]);
      if (i == hang) m_tf = 1;
      if (bad) begin
        if (m_e == 0) m_ff = i;
        m_e++;
      end
    end
    chk("err_count", 64'(err_count), 64'(m_e));
    chk("timeout_flag", 64'(timeout_flag), 64'(m_tf));
    chk("first_fail", 64'(first_fail), 64'(m_ff));
    chk("n_starts", 64'(n_starts), 64'(n));
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_core_rst", 64'(cif.core_rst), 64'(1));
  endtask

  initial begin
    rst = 1; ld_we = 0; ld_sel = 0; ld_addr = '0; ld_data = '0; run = 0; vec_count = '0;
`ifdef HASH_VEC_DIGEST_LOG_EN
    log_addr = '0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_core_rst", 64'(cif.core_rst), 64'(1));
    chk("reset_start", 64'(cif.core_start), 64'(0));
    chk("reset_msg", 64'(cif.core_msg), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_seq_done", 64'(seq_done), 64'(0));
    chk("reset_err", 64'(err_count), 64'(0));
    chk("reset_timeout", 64'(timeout_flag), 64'(0));
    chk("reset_first_fail", 64'(first_fail), 64'(0));
    rst = 0;

    // Four good vectors.
    for (int i = 0; i < 4; i++) begin
      m_msg[i] = $urandom; m_exp[i] = hf(m_msg[i]);
      load(0, i, m_msg[i]); load(1, i, m_exp[i]);
    end
    do_run(4, -1, 0, 0, -1);
    chk("t1_seq_done", 64'(seq_done), 64'(1));
    chk("t1_err_lit", 64'(err_count), 64'(0));
    chk("t1_to_lit", 64'(timeout_flag), 64'(0));

    // One corrupted expected digest.
    m_exp[2] ^= 32'h1; load(1, 2, m_exp[2]);
    do_run(4, -1, 0, 0, -1);
    chk("t2_err_lit", 64'(err_count), 64'(1));
    chk("t2_ff_lit", 64'(first_fail), 64'(2));

    // Vector 1 never completes.
    m_exp[2] ^= 32'h1; load(1, 2, m_exp[2]);
    do_run(4, 1, 0, 0, -1);
    chk("t3_to_lit", 64'(timeout_flag), 64'(1));
    chk("t3_err_lit", 64'(err_count), 64'(1));
    chk("t3_ff_lit", 64'(first_fail), 64'(1));
`ifdef HASH_VEC_DIGEST_LOG_EN
    log_chk(1, 32'hFFFF_FFFF);
`endif

    // Full table, every expectation wrong, vec_count=0, write to msg[0] alongside run.
    for (int i = 0; i < NV; i++) begin
      m_msg[i] = $urandom; m_exp[i] = ~hf(m_msg[i]);
      load(0, i, m_msg[i]); load(1, i, m_exp[i]);
    end
    do_run(0, -1, 1, 0, -1);
    chk("t4_err_lit", 64'(err_count), 64'(64));

    // vec_count above the table depth clamps to the full table.
    for (int i = 0; i < NV; i++) begin
      m_exp[i] = hf(m_msg[i]) ^ ((i % 9 == 5) ? 32'h8000_0000 : 32'h0);
      load(1, i, m_exp[i]);
    end
    do_run(100, -1, 0, 0, -1);

    // Reset in WAIT_DONE of vector 3, then restart from the top.
    m_exp[0] ^= 32'h10; load(1, 0, m_exp[0]);
    lat_force = 10;
    do_run(4, -1, 0, 0, 3);
    lat_force = 0;
    do_run(4, -1, 0, 0, -1);
    chk("t5_err_lit", 64'(err_count), 64'(1));
    chk("t5_ff_lit", 64'(first_fail), 64'(0));

    // Loads and run while busy must be dropped.
    m_exp[0] ^= 32'h10; load(1, 0, m_exp[0]);
    do_run(4, -1, 0, 1, -1);
`ifdef HASH_VEC_DIGEST_LOG_EN
    log_chk(1, hf(m_msg[1]));
`endif
    do_run(4, -1, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
